maxpool2x2: RTL and testbench

2x2 stride-2 max-pooling stage that sits directly downstream of the ReLU stage in the CNN datapath. It uses the same memory-style streaming interface: start/done handshake, an address-driven read port into the source buffer, and an address/data/write-strobe port into the destination buffer. It reads each 2x2 window of an IN_ROWS x IN_COLS feature map and writes one signed maximum per window into an (IN_ROWS/2) x (IN_COLS/2) output map.

---
 rtl/maxpool2x2.sv | 115 +++++++++++
 tb/tb_maxpool2x2.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max-pool over an IN_ROWS x IN_COLS map held in a source buffer,
// writing one signed maximum per window into a destination buffer.
module maxpool2x2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int IN_ROWS       = 4,
  parameter int IN_COLS       = 4,
  parameter int ADR_IN_WIDTH  = 4,
  parameter int ADR_OUT_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     axisif_in_start,
  output logic                     axisif_out_done,
  output logic [ADR_IN_WIDTH-1:0]  out_adrIn,
  input  logic [DATA_WIDTH-1:0]    in_dataIn,
  output logic [ADR_OUT_WIDTH-1:0] out_adrOut,
  output logic [DATA_WIDTH-1:0]    out_dataOut,
  output logic                     out_wr
);

  localparam int HR   = IN_ROWS / 2;
  localparam int HC   = IN_COLS / 2;
  localparam int WR_W = (HR > 1) ? $clog2(HR) : 1;
  localparam int WC_W = (HC > 1) ? $clog2(HC) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                       state, state_nxt;
  logic [WR_W-1:0]              wr, wr_nxt;
  logic [WC_W-1:0]              wc, wc_nxt;
  logic [1:0]                   k;
  logic signed [DATA_WIDTH-1:0] max_q, win_max;
  logic                         last_col, last_win;

  // Source address of element k (dr=k[1], dc=k[0]) of window (r,c).
  function automatic logic [ADR_IN_WIDTH-1:0] rd_adr(input logic [WR_W-1:0] r,
                                                      input logic [WC_W-1:0] c,
                                                      input logic [1:0]      kk);
    rd_adr = ADR_IN_WIDTH'((2 * int'(r) + int'(kk[1])) * IN_COLS
                           + 2 * int'(c) + int'(kk[0]));
  endfunction

  always_comb begin
    last_col = (wc == WC_W'(HC - 1));
    last_win = last_col && (wr == WR_W'(HR - 1));
    wc_nxt   = last_col ? '0 : wc + 1'b1;
    wr_nxt   = last_col ? wr + 1'b1 : wr;
    // First element loads unconditionally so all-negative windows stay negative.
    win_max  = (k == 2'd0 || $signed(in_dataIn) > max_q) ? $signed(in_dataIn) : max_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    out_wr          = 1'b0;
    axisif_out_done = 1'b0;
    case (state)
      IDLE:  if (axisif_in_start) state_nxt = READ;
      READ:  if (k == 2'd3) state_nxt = WRITE;
      WRITE: begin
        out_wr    = 1'b1;
        state_nxt = last_win ? DONE : READ;
      end
      DONE: begin
        axisif_out_done = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read address is registered one cycle ahead so it is stable for the whole read cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr          <= '0;
      wc          <= '0;
      k           <= '0;
      max_q       <= '0;
      out_adrIn   <= '0;
      out_adrOut  <= '0;
      out_dataOut <= '0;
    end else begin
      case (state)
        IDLE: if (axisif_in_start) begin
          wr        <= '0;
          wc        <= '0;
          k         <= '0;
          out_adrIn <= rd_adr('0, '0, 2'd0);
        end
        READ: begin
          max_q <= win_max;
          if (k == 2'd3) begin
            out_dataOut <= win_max;
            out_adrOut  <= ADR_OUT_WIDTH'(int'(wr) * HC + int'(wc));
          end else begin
            k         <= k + 2'd1;
            out_adrIn <= rd_adr(wr, wc, k + 2'd1);
          end
        end
        WRITE: begin
          wr <= wr_nxt;
          wc <= wc_nxt;
          k  <= '0;
          if (!last_win) out_adrIn <= rd_adr(wr_nxt, wc_nxt, 2'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// Bench for maxpool2x2: cycle-exact frame checks against a window-max model,
// plus a 4x8 instance for the wider-map configuration.
module tb_maxpool2x2;

  logic        clk = 1'b0;
  logic        rst, start, done, out_wr;
  logic [3:0]  adr_in;
  logic [31:0] in_data, dat_out;
  logic [1:0]  adr_out;
  logic [31:0] src_mem [16];

  logic        rst8, start8, done8, wr8;
  logic [4:0]  adr_in8;
  logic [31:0] in_data8, dat_out8;
  logic [2:0]  adr_out8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign in_data  = src_mem[adr_in];
  assign in_data8 = {27'b0, adr_in8};

  maxpool2x2 dut (
    .clk(clk), .rst(rst), .axisif_in_start(start), .axisif_out_done(done),
    .out_adrIn(adr_in), .in_dataIn(in_data), .out_adrOut(adr_out),
    .out_dataOut(dat_out), .out_wr(out_wr)
  );

  maxpool2x2 #(.IN_ROWS(4), .IN_COLS(8), .ADR_IN_WIDTH(5), .ADR_OUT_WIDTH(3)) dut8 (
    .clk(clk), .rst(rst8), .axisif_in_start(start8), .axisif_out_done(done8),
    .out_adrIn(adr_in8), .in_dataIn(in_data8), .out_adrOut(adr_out8),
    .out_dataOut(dat_out8), .out_wr(wr8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address of element s (row-major within the window) of window i.
  function automatic int win_adr(input int cols, input int i, input int s);
    int r = i / (cols / 2);
    int c = i % (cols / 2);
    return (2 * r + s / 2) * cols + 2 * c + s % 2;
  endfunction

  function automatic logic [31:0] win_max(input int i);
    logic signed [31:0] m = src_mem[win_adr(4, i, 0)];
    for (int s = 1; s < 4; s++)
      if ($signed(src_mem[win_adr(4, i, s)]) > m) m = src_mem[win_adr(4, i, s)];
    return m;
  endfunction

  function automatic logic [31:0] win_max8(input int i);
    int m = win_adr(8, i, 0);
    for (int s = 1; s < 4; s++)
      if (win_adr(8, i, s) > m) m = win_adr(8, i, s);
    return m;
  endfunction

  // Called at a negedge with the DUT in IDLE; checks every cycle of one frame
  // and returns at the negedge of the IDLE cycle that follows DONE.
  task automatic run_frame(input bit hold);
    int i, s;
    start = 1'b1;
    @(posedge clk);
    for (int rel = 1; rel <= 22; rel++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      i = (rel - 1) / 5;
      s = (rel - 1) % 5;
      if (rel == 22) begin
        chk("idle_wr", out_wr, 0);
        chk("idle_done", done, 0);
        chk("idle_adr_in", adr_in, 15);
      end else if (rel == 21) begin
        chk("done", done, 1);
        chk("done_wr", out_wr, 0);
        chk("done_adr_in", adr_in, 15);
      end else if (s < 4) begin
        chk($sformatf("rd_adr w%0d k%0d", i, s), adr_in, win_adr(4, i, s));
        chk("rd_wr", out_wr, 0);
        chk("rd_done", done, 0);
      end else begin
        chk($sformatf("wr w%0d", i), out_wr, 1);
        chk($sformatf("wr_adr w%0d", i), adr_out, i);
        chk($sformatf("wr_dat w%0d", i), dat_out, win_max(i));
        chk("wr_done", done, 0);
        chk("wr_adr_in", adr_in, win_adr(4, i, 3));
      end
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < 16; j++)
      src_mem[j] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 6)) - 32'd3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    bit got_done;

    rst = 1'b1; rst8 = 1'b1; start = 1'b0; start8 = 1'b0;
    for (int j = 0; j < 16; j++) src_mem[j] = 32'(j) - 32'd8;
    repeat (2) @(negedge clk);
    chk("rst_adr_in", adr_in, 0);
    chk("rst_adr_out", adr_out, 0);
    chk("rst_dat_out", dat_out, 0);
    chk("rst_wr", out_wr, 0);
    chk("rst_done", done, 0);
    chk("rst8_wr", wr8, 0);
    rst = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    // data = address - 8
    run_frame(1'b0);

    // most-negative everywhere
    for (int j = 0; j < 16; j++) src_mem[j] = 32'h8000_0000;
    run_frame(1'b0);

    repeat (4) begin
      fill_random();
      run_frame(1'b0);
    end

    // start held through two back-to-back frames
    fill_random();
    run_frame(1'b1);
    run_frame(1'b1);
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_hold_wr", out_wr, 0);
      chk("post_hold_done", done, 0);
    end

    // reset during window 1, k=2
    for (int j = 0; j < 16; j++) src_mem[j] = 32'(j) - 32'd8;
    start = 1'b1;
    @(posedge clk);
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_adr_in", adr_in, win_adr(4, 1, 2));
    chk("pre_rst_dat_out", dat_out, win_max(0));
    rst = 1'b1;
    #1;
    chk("arst_adr_in", adr_in, 0);
    chk("arst_adr_out", adr_out, 0);
    chk("arst_dat_out", dat_out, 0);
    chk("arst_wr", out_wr, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      chk("post_rst_wr", out_wr, 0);
      chk("post_rst_done", done, 0);
    end
    run_frame(1'b0);
    fill_random();
    run_frame(1'b0);

    // 4x8 configuration, data = address
    start8 = 1'b1;
    @(posedge clk);
    got_done = 1'b0;
    for (int rel = 1; rel <= 60 && !got_done; rel++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (wr8) begin
        wa.push_back(32'(adr_out8));
        wd.push_back(dat_out8);
      end
      if (done8) begin
        got_done = 1'b1;
        chk("d8_done_cycle", rel, 41);
        chk("d8_done_wr", wr8, 0);
      end
    end
    chk("d8_done_seen", got_done, 1);
    chk("d8_nwr", wa.size(), 8);
    foreach (wa[j]) begin
      chk($sformatf("d8_adr %0d", j), wa[j], j);
      chk($sformatf("d8_dat %0d", j), wd[j], win_max8(j));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
